// File: rtl/write_back_arbiter.sv
// Small circular FIFO: registered pointers with an extra wrap bit, head visible combinationally.
// Pushes while full and pops while empty are ignored.
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];

  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign head_dat = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_vld && !full) wptr <= wptr + 1'b1;
      if (pop_vld && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !full) mem[wptr[AW-1:0]] <= push_dat;
  end
endmodule

// Merges NUM_CH write-back channels onto one registered RF write port; ch0 latency 1, buffered channels >= 2.
// ch0 is stalled only on a forced anti-starvation cycle; buffered channels stall when their FIFO is full.
module write_back_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_CH       = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      in_valid,
  output logic [NUM_CH-1:0]      in_ready,
  input  logic [NUM_CH-1:0]      in_reg_write,
  input  logic [2*NUM_CH-1:0]    in_result_src,
  input  logic [3*NUM_CH-1:0]    in_funct3,
  input  logic [5*NUM_CH-1:0]    in_rd,
  input  logic [XLEN*NUM_CH-1:0] in_alu_result,
  input  logic [XLEN*NUM_CH-1:0] in_read_data,
  input  logic [XLEN*NUM_CH-1:0] in_pc_plus4,
  output logic                   rf_we,
  output logic [4:0]             rf_rd,
  output logic [XLEN-1:0]        rf_wdata,
  output logic                   wb_pending
);
  localparam int CW = $clog2(NUM_CH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] dat;
  } wb_ent_t;

  function automatic logic [XLEN-1:0] sel_result(
    input logic [1:0]      src,
    input logic [2:0]      f3,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] rdat,
    input logic [XLEN-1:0] pc
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = rdat[{alu[1:0], 3'b000} +: 8];
    h = alu[1] ? rdat[31:16] : rdat[15:0];
    sel_result = alu;
    if (src == 2'b10) begin
      sel_result = pc;
    end else if (src == 2'b01) begin
      case (f3)
        3'b000:  sel_result = {{(XLEN-8){b[7]}}, b};
        3'b001:  sel_result = {{(XLEN-16){h[15]}}, h};
        3'b100:  sel_result = {{(XLEN-8){1'b0}}, b};
        3'b101:  sel_result = {{(XLEN-16){1'b0}}, h};
        default: sel_result = rdat;
      endcase
    end
  endfunction

  logic [XLEN-1:0] sel_dat [NUM_CH];
  wb_ent_t         fifo_head [NUM_CH];
  logic [NUM_CH-1:0] wr_req, fifo_full, fifo_empty;
  logic [CW-1:0]   rr_ptr, gnt_idx;
  logic [SW-1:0]   starve_cnt;
  logic            any_ne, forced, ch0_win, fifo_gnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel_dat[i] = sel_result(in_result_src[2*i +: 2], in_funct3[3*i +: 3],
                                   in_alu_result[XLEN*i +: XLEN], in_read_data[XLEN*i +: XLEN],
                                   in_pc_plus4[XLEN*i +: XLEN]);
    assign wr_req[i]  = in_reg_write[i] && (in_rd[5*i +: 5] != 5'd0);

    if (i == 0) begin : g_direct
      assign fifo_full[0]  = 1'b0;
      assign fifo_empty[0] = 1'b1;
      assign fifo_head[0]  = '0;
    end else begin : g_buf
      wb_ent_t ent;
      logic    push, pop;
      assign ent  = '{rd: in_rd[5*i +: 5], dat: sel_dat[i]};
      assign push = in_valid[i] && !fifo_full[i] && wr_req[i];
      assign pop  = fifo_gnt && (gnt_idx == CW'(i));

      wb_fifo #(.W($bits(wb_ent_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat (ent),
        .pop_vld  (pop),
        .head_dat (fifo_head[i]),
        .full     (fifo_full[i]),
        .empty    (fifo_empty[i])
      );
    end
  end

  assign any_ne     = !(&fifo_empty);
  assign wb_pending = any_ne;
  assign forced     = any_ne && (starve_cnt == SW'(STARVE_LIMIT));
  // A dropped ch0 transfer carries no write, so it never steals the port from a FIFO.
  assign ch0_win    = in_valid[0] && wr_req[0] && !forced;

  always_comb begin
    in_ready    = ~fifo_full;
    in_ready[0] = !forced;
  end

  always_comb begin
    int idx;
    idx      = 0;
    fifo_gnt = 1'b0;
    gnt_idx  = '0;
    if (!ch0_win) begin
      for (int off = 0; off < NUM_CH-1; off++) begin
        idx = ((int'(rr_ptr) - 1 + off) % (NUM_CH-1)) + 1;
        if (!fifo_gnt && !fifo_empty[idx]) begin
          fifo_gnt = 1'b1;
          gnt_idx  = CW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      rr_ptr     <= CW'(1);
      starve_cnt <= '0;
    end else begin
      rf_we <= ch0_win || fifo_gnt;
      if (ch0_win) begin
        rf_rd    <= in_rd[4:0];
        rf_wdata <= sel_dat[0];
      end else if (fifo_gnt) begin
        rf_rd    <= fifo_head[gnt_idx].rd;
        rf_wdata <= fifo_head[gnt_idx].dat;
      end
      if (fifo_gnt) rr_ptr <= (gnt_idx == CW'(NUM_CH-1)) ? CW'(1) : gnt_idx + CW'(1);
      if (fifo_gnt || !any_ne) starve_cnt <= '0;
      else if (ch0_win)        starve_cnt <= starve_cnt + SW'(1);
    end
  end
endmodule

// File: tb/tb_write_back_arbiter.sv
// Bench for write_back_arbiter with three channels; rd ranges tag the source channel.
module tb_write_back_arbiter;
  localparam int XLEN = 32;
  localparam int NCH  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v [NCH], rw [NCH];
  logic [1:0]  src [NCH];
  logic [2:0]  f3 [NCH];
  logic [4:0]  rd [NCH];
  logic [31:0] alu [NCH], rdat [NCH], pc [NCH];

  logic [NCH-1:0]      in_valid, in_ready, in_reg_write;
  logic [2*NCH-1:0]    in_result_src;
  logic [3*NCH-1:0]    in_funct3;
  logic [5*NCH-1:0]    in_rd;
  logic [XLEN*NCH-1:0] in_alu_result, in_read_data, in_pc_plus4;
  logic                rf_we, wb_pending;
  logic [4:0]          rf_rd;
  logic [XLEN-1:0]     rf_wdata;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      in_valid[i]                 = v[i];
      in_reg_write[i]             = rw[i];
      in_result_src[2*i +: 2]     = src[i];
      in_funct3[3*i +: 3]         = f3[i];
      in_rd[5*i +: 5]             = rd[i];
      in_alu_result[XLEN*i +: XLEN] = alu[i];
      in_read_data[XLEN*i +: XLEN]  = rdat[i];
      in_pc_plus4[XLEN*i +: XLEN]   = pc[i];
    end
  end

  write_back_arbiter #(.XLEN(XLEN), .NUM_CH(NCH), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_result_src (in_result_src),
    .in_funct3     (in_funct3),
    .in_rd         (in_rd),
    .in_alu_result (in_alu_result),
    .in_read_data  (in_read_data),
    .in_pc_plus4   (in_pc_plus4),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wdata      (rf_wdata),
    .wb_pending    (wb_pending)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] q0 [$], q1 [$], q2 [$];
  logic [4:0]  wr_log [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int chan_of(input logic [4:0] r);
    if (r >= 5'd1 && r <= 5'd9)        return 0;
    else if (r >= 5'd10 && r <= 5'd19) return 1;
    else if (r >= 5'd20 && r <= 5'd29) return 2;
    return -1;
  endfunction

  function automatic logic [31:0] exp_dat(input logic [1:0] s, input logic [2:0] f,
                                          input logic [31:0] a, input logic [31:0] d,
                                          input logic [31:0] p);
    logic [31:0] sb, sh;
    sb = d >> (8 * a[1:0]);
    sh = a[1] ? (d >> 16) : d;
    if (s == 2'd2) return p;
    if (s != 2'd1) return a;
    case (f)
      3'd0:    return {{24{sb[7]}}, sb[7:0]};
      3'd4:    return {24'd0, sb[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic idle();
    for (int i = 0; i < NCH; i++) begin
      v[i] = 1'b0; rw[i] = 1'b1; src[i] = 2'd0; f3[i] = 3'd0;
      rd[i] = 5'd0; alu[i] = 32'd0; rdat[i] = 32'd0; pc[i] = 32'd0;
    end
  endtask

  task automatic set_ch(input int c, input logic [4:0] r, input logic [1:0] s, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    v[c] = 1'b1; rw[c] = 1'b1; rd[c] = r; src[c] = s; f3[c] = f;
    alu[c] = a; rdat[c] = d; pc[c] = p;
  endtask

  task automatic record();
    logic [36:0] e;
    for (int c = 0; c < NCH; c++) begin
      if (v[c] && in_ready[c] && rw[c] && rd[c] != 5'd0) begin
        e = {rd[c], exp_dat(src[c], f3[c], alu[c], rdat[c], pc[c])};
        if (c == 0)      q0.push_back(e);
        else if (c == 1) q1.push_back(e);
        else             q2.push_back(e);
      end
    end
  endtask

  // One clock: accepts are recorded mid-cycle, then returns just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    #1 record();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!wb_pending && q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      cyc();
    end
    chk("drain_pending", wb_pending, 0);
    chk("drain_scoreboard", q0.size() + q1.size() + q2.size(), 0);
  endtask

  logic [36:0] mon_e;
  int          mon_c;
  logic        mon_ok;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      wr_log.push_back(rf_rd);
      mon_c  = chan_of(rf_rd);
      mon_ok = 1'b1;
      if (mon_c == 0 && q0.size() > 0)      mon_e = q0.pop_front();
      else if (mon_c == 1 && q1.size() > 0) mon_e = q1.pop_front();
      else if (mon_c == 2 && q2.size() > 0) mon_e = q2.pop_front();
      else begin
        mon_ok = 1'b0;
        chk("unexpected_rf_we", rf_we, 0);
      end
      if (mon_ok) begin
        chk("sb_rd", rf_rd, mon_e[36:32]);
        chk("sb_wdata", rf_wdata, mon_e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pending", wb_pending, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_in_ready", in_ready, 3'b111);

    // ch0 direct path, latency one edge
    set_ch(0, 5'd5, 2'd0, 3'd0, 32'h1234, 32'hdead, 32'h40);
    cyc(); idle();
    chk("t1_we", rf_we, 1);
    chk("t1_rd", rf_rd, 5);
    chk("t1_wdata", rf_wdata, 32'h00001234);
    set_ch(0, 5'd6, 2'd2, 3'd0, 32'h1, 32'h2, 32'h2000);
    cyc(); idle();
    chk("t1_pc4", rf_wdata, 32'h2000);
    set_ch(0, 5'd7, 2'd3, 3'd0, 32'hABCD, 32'h2, 32'h3);
    cyc(); idle();
    chk("t1_src11", rf_wdata, 32'hABCD);
    cyc();
    chk("t1_idle_we", rf_we, 0);
    chk("t1_hold_rd", rf_rd, 7);

    // buffered load path, two edges
    set_ch(1, 5'd10, 2'd1, 3'd0, 32'h102, 32'h00800000, 32'h0);
    cyc(); idle();
    chk("t2_lat_we", rf_we, 0);
    chk("t2_pending", wb_pending, 1);
    cyc();
    chk("t2_lb_we", rf_we, 1);
    chk("t2_lb_rd", rf_rd, 10);
    chk("t2_lb", rf_wdata, 32'hFFFFFF80);
    set_ch(1, 5'd11, 2'd1, 3'd4, 32'h102, 32'h00800000, 32'h0);
    cyc(); idle(); cyc();
    chk("t2_lbu", rf_wdata, 32'h00000080);
    for (int k = 0; k < 8; k++) begin
      set_ch(1, 5'(12 + k), 2'd1, 3'($urandom_range(0, 7)), 32'(k), $urandom, 32'h0);
      cyc();
    end
    idle();
    drain();

    // fill ch1 behind a busy ch0, then drain
    for (int k = 0; k < 4; k++) begin
      set_ch(0, 5'(1 + k), 2'd0, 3'd0, 32'(k), 32'h0, 32'h0);
      set_ch(1, 5'(12 + k), 2'd0, 3'd0, 32'h300 + 32'(k), 32'h0, 32'h0);
      chk("t3_rdy_fill", in_ready[1], 1);
      cyc();
    end
    set_ch(0, 5'd5, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0);
    set_ch(1, 5'd16, 2'd0, 3'd0, 32'h316, 32'h0, 32'h0);
    chk("t3_full", in_ready[1], 0);
    chk("t3_pending", wb_pending, 1);
    cyc();
    v[0] = 1'b0;
    chk("t3_full_at_pop", in_ready[1], 0);
    cyc();
    chk("t3_rdy_back", in_ready[1], 1);
    cyc();
    idle();
    drain();

    // starvation: one ch1 entry behind a continuous ch0 stream
    wr_log.delete();
    set_ch(0, 5'd1, 2'd0, 3'd0, 32'h4100, 32'h0, 32'h0);
    set_ch(1, 5'd17, 2'd0, 3'd0, 32'h4444, 32'h0, 32'h0);
    cyc();
    v[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_ch(0, 5'(1 + ((k + 1) % 9)), 2'd0, 3'd0, 32'h4000 + 32'(k), 32'h0, 32'h0);
      chk("t4_rdy0", in_ready[0], (k == 8) ? 1'b0 : 1'b1);
      cyc();
    end
    idle();
    drain();
    chk("t4_nwrites", wr_log.size(), 11);
    if (wr_log.size() == 11) begin
      chk("t4_8th_ch0", chan_of(wr_log[8]), 0);
      chk("t4_forced_rd", wr_log[9], 17);
      chk("t4_after_ch0", chan_of(wr_log[10]), 0);
    end

    // reset with entries queued
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 5'(1 + k), 2'd0, 3'd0, 32'h600 + 32'(k), 32'h0, 32'h0);
      set_ch(1, 5'(12 + k), 2'd0, 3'd0, 32'h610 + 32'(k), 32'h0, 32'h0);
      cyc();
    end
    idle();
    chk("t6_pre_we", rf_we, 1);
    chk("t6_pre_pending", wb_pending, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_we", rf_we, 0);
    chk("t6_pending", wb_pending, 0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_log.delete();
    repeat (6) cyc();
    chk("t6_no_stale", wr_log.size(), 0);
    chk("t6_pending_after", wb_pending, 0);

    // round robin between ch1 and ch2
    wr_log.delete();
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 5'(1 + k), 2'd0, 3'd0, 32'h700 + 32'(k), 32'h0, 32'h0);
      set_ch(1, 5'(10 + k), 2'd2, 3'd0, 32'h0, 32'h0, 32'h710 + 32'(k));
      set_ch(2, 5'(20 + k), 2'd0, 3'd0, 32'h720 + 32'(k), 32'h0, 32'h0);
      cyc();
    end
    idle();
    drain();
    chk("t5_nwrites", wr_log.size(), 9);
    if (wr_log.size() == 9) begin
      for (int k = 3; k < 9; k++) chk("t5_grant_ch", chan_of(wr_log[k]), (k % 2 == 1) ? 1 : 2);
    end
    for (int k = 0; k < 4; k++) begin
      set_ch(0, (k % 2 == 0) ? 5'd0 : 5'd9, 2'(k), 3'd0, 32'h800, 32'h0, 32'h0);
      rw[0] = (k % 2 == 0);
      set_ch(1, 5'd13, 2'd0, 3'd0, 32'h810, 32'h0, 32'h0);
      rw[1] = 1'b0;
      set_ch(2, 5'd0, 2'd1, 3'd2, 32'h820, 32'h5, 32'h0);
      cyc();
      chk("t5_drop_we", rf_we, 0);
      chk("t5_drop_pending", wb_pending, 0);
    end
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
